// File: rtl/stopwatch_display_scan_pkg.sv
// Segment patterns and scan types shared by the display scanner.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package stopwatch_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Display bundle: BCD time word in, multiplexed 7-seg drive out.
// master = time source side, slave = display scanner.
interface stopwatch_display_scan_if;
  logic [15:0] Q;
  logic        STOPPED;
  logic        BLANK_LZ;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;

  modport master (
    output Q, STOPPED, BLANK_LZ,
    input  SEG, DP, AN
  );

  modport slave (
    input  Q, STOPPED, BLANK_LZ,
    output SEG, DP, AN
  );
endinterface

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-seg pattern.
// Ports: bcd (4-bit digit) in, seg {g..a} out; 10-15 give a dash.
module bcd_to_seg7
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// 4-digit MM:SS multiplexed 7-seg scanner with snapshot and blink.
// Ports: clk_in, RESET_N (sync, low), disp (slave: Q/STOPPED/BLANK_LZ in, SEG/DP/AN out).
module stopwatch_display_scan
  import stopwatch_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                     clk_in,
  input logic                     RESET_N,
  stopwatch_display_scan_if.slave disp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [3:0] AN_INV  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_INV  = SEG_ACTIVE_LOW;

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [FW-1:0] frames;
  logic [15:0]   snap;
  logic          hidden;
  logic          load_pend;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          tick;
  logic          frame_tick;
  logic          frame_wrap;
  logic [15:0]   view;
  logic [3:0]    nib;
  logic [6:0]    pat;
  logic          lit;
  logic [3:0]    an_hi;
  logic [6:0]    seg_hi;
  logic          dp_hi;

  assign tick       = (presc == PW'(REFRESH_DIV - 1));
  assign frame_tick = tick && (idx == 2'd3);
  assign frame_wrap = (frames == FW'(BLINK_FRAMES - 1));

  // First cycle after reset decodes the word being latched,
  // so digit 0 of the first frame is already the fresh value.
  assign view = load_pend ? disp.Q : snap;

  always_comb begin
    nib = view[3:0];
    case (idx)
      2'd0: nib = view[3:0];
      2'd1: nib = view[7:4];
      2'd2: nib = view[11:8];
      2'd3: nib = view[15:12];
      default: nib = view[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (nib),
    .seg (pat)
  );

  // Hidden phase only counts while stopped; releasing STOPPED
  // shows the very next scan step without waiting a cycle.
  always_comb begin
    lit = !(hidden && disp.STOPPED);
    if (idx == 2'd3 && disp.BLANK_LZ && nib == 4'd0)
      lit = 1'b0;
    an_hi  = lit ? (4'b0001 << idx) : 4'b0000;
    seg_hi = lit ? pat : SEG_OFF;
    dp_hi  = lit && (idx == 2'd2);
  end

  always_ff @(posedge clk_in) begin
    if (!RESET_N) begin
      presc     <= '0;
      idx       <= 2'd0;
      frames    <= '0;
      snap      <= 16'h0000;
      hidden    <= 1'b0;
      load_pend <= 1'b1;
      an_q      <= AN_INV;
      seg_q     <= SEG_INV;
      dp_q      <= DP_INV;
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      load_pend <= 1'b0;
      if (tick)
        idx <= idx + 1'b1;
      if (load_pend || frame_tick)
        snap <= disp.Q;
      if (!disp.STOPPED) begin
        frames <= '0;
        hidden <= 1'b0;
      end else if (frame_tick) begin
        if (frame_wrap) begin
          frames <= '0;
          hidden <= ~hidden;
        end else begin
          frames <= frames + 1'b1;
        end
      end
      an_q  <= an_hi ^ AN_INV;
      seg_q <= seg_hi ^ SEG_INV;
      dp_q  <= dp_hi ^ DP_INV;
    end
  end

  assign disp.AN  = an_q;
  assign disp.SEG = seg_q;
  assign disp.DP  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for stopwatch_display_scan: directed plan plus random run,
// every cycle checked against a time-indexed behavioural model.
module tb_stopwatch_display_scan;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_display_scan_if bus ();

  stopwatch_display_scan #(
    .REFRESH_DIV    (DIV),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_in  (clk),
    .RESET_N (rst_n),
    .disp    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model state: edges since release, displayed/pending words,
  // frame ticks seen since STOPPED was last low
  int          n = 0;
  int          run = 0;
  logic [15:0] msnap = 16'h0;
  logic [15:0] pend = 16'h0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h",
               name, $time, got, exp);
    end
  endtask

  task automatic model();
    int          idx;
    logic [3:0]  nib;
    logic [15:0] sh;
    logic        on;
    if (!rst_n) begin
      e_an = 4'hF;
      e_seg = 7'h7F;
      e_dp = 1'b1;
      n = 0;
      run = 0;
      return;
    end
    if (n == 0) msnap = bus.Q;
    else if (n % FRAME == 0) msnap = pend;
    idx = (n / DIV) % 4;
    sh = msnap >> (4 * idx);
    nib = sh[3:0];
    on = !(bus.STOPPED && ((run / BF) % 2 == 1));
    if (idx == 3 && bus.BLANK_LZ && nib == 4'd0) on = 1'b0;
    e_an = on ? ~(4'b0001 << idx) : 4'hF;
    e_seg = on ? ~seg_of(nib) : 7'h7F;
    e_dp = !(on && idx == 2);
    if ((n + 1) % FRAME == 0) pend = bus.Q;
    if (!bus.STOPPED) run = 0;
    else if ((n + 1) % FRAME == 0) run++;
    n++;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("AN", {12'h0, bus.AN}, {12'h0, e_an});
    chk("SEG", {9'h0, bus.SEG}, {9'h0, e_seg});
    chk("DP", {15'h0, bus.DP}, {15'h0, e_dp});
  endtask

  initial begin
    logic [15:0] q;
    bus.Q = 16'h1020;
    bus.STOPPED = 1'b0;
    bus.BLANK_LZ = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_AN", {12'h0, bus.AN}, 16'h000F);
    chk("rst_SEG", {9'h0, bus.SEG}, 16'h007F);
    chk("rst_DP", {15'h0, bus.DP}, 16'h0001);
    rst_n = 1'b1;

    for (int k = 0; k <= 230; k++) begin
      step();
      case (k)
        0: begin
          chk("lit_an0", {12'h0, bus.AN}, 16'h000E);
          chk("lit_seg0", {9'h0, bus.SEG}, 16'h0040);
        end
        4: begin
          chk("lit_an1", {12'h0, bus.AN}, 16'h000D);
          chk("lit_seg2", {9'h0, bus.SEG}, 16'h0024);
        end
        5: bus.Q = 16'h4930;
        8: begin
          chk("lit_an2", {12'h0, bus.AN}, 16'h000B);
          chk("tear_seg", {9'h0, bus.SEG}, 16'h0040);
          chk("colon", {15'h0, bus.DP}, 16'h0000);
        end
        12: begin
          chk("lit_an3", {12'h0, bus.AN}, 16'h0007);
          chk("lit_seg1", {9'h0, bus.SEG}, 16'h0079);
        end
        20: chk("lit_seg3", {9'h0, bus.SEG}, 16'h0030);
        28: chk("lit_seg4", {9'h0, bus.SEG}, 16'h0019);
        31: begin
          bus.Q = 16'h0512;
          bus.BLANK_LZ = 1'b1;
        end
        60: begin
          chk("lz_an", {12'h0, bus.AN}, 16'h000F);
          chk("lz_dp", {15'h0, bus.DP}, 16'h0001);
        end
        61: bus.BLANK_LZ = 1'b0;
        62: begin
          chk("nolz_an", {12'h0, bus.AN}, 16'h0007);
          chk("nolz_seg", {9'h0, bus.SEG}, 16'h0040);
        end
        63: bus.Q = 16'h00A0;
        84: chk("dash", {9'h0, bus.SEG}, 16'h003F);
        95: bus.STOPPED = 1'b1;
        130: chk("blink_off", {12'h0, bus.AN}, 16'h000F);
        165: chk("blink_on", {12'h0, bus.AN}, 16'h000D);
        200: bus.STOPPED = 1'b0;
        201: chk("unstop", {12'h0, bus.AN}, 16'h000B);
        215: begin
          rst_n = 1'b0;
          bus.Q = 16'h5678;
        end
        216: begin
          chk("midrst_an", {12'h0, bus.AN}, 16'h000F);
          rst_n = 1'b1;
        end
        217: begin
          chk("restart_an", {12'h0, bus.AN}, 16'h000E);
          chk("restart_seg", {9'h0, bus.SEG}, 16'h0000);
        end
        default: ;
      endcase
    end

    for (int k = 0; k < 3000; k++) begin
      step();
      if ($urandom_range(19) == 0) begin
        q = 16'($urandom);
        if ($urandom_range(1) == 1) q[15:12] = 4'h0;
        bus.Q = q;
      end
      if ($urandom_range(79) == 0) bus.STOPPED = ~bus.STOPPED;
      if ($urandom_range(39) == 0) bus.BLANK_LZ = ~bus.BLANK_LZ;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(399) == 0) rst_n = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
